// File: rtl/operand_gen_if.sv
// Operand-pair stream between operand_gen (master) and the downstream add/sub stage (slave).
interface operand_gen_if #(
    parameter int unsigned OP_W = 4
);
    logic            out_valid;
    logic            out_ready;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;

    modport master (
        output out_valid,
        output a,
        output b,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  a,
        input  b,
        output out_ready
    );
endinterface

// File: rtl/operand_gen.sv
// LFSR-driven operand-pair generator: emits count_n (a, b) pairs over a valid/ready stream,
// then pulses done for one cycle. All outputs are registered.
module operand_gen #(
    parameter int unsigned OP_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          count_n,
    input  logic [7:0]          seed,
    operand_gen_if.master       out,
    output logic                busy,
    output logic                done,
    output logic [7:0]          sent_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e     state_q;
    logic [7:0] lfsr_q;
    logic [7:0] count_q;

    logic [7:0] seed_eff;
    logic [7:0] lfsr_nxt;
    logic [7:0] sent_inc;
    logic       hs;

    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced by 8'h01.
    assign seed_eff = (seed == 8'h00) ? 8'h01 : seed;
    assign lfsr_nxt = lfsr_step(lfsr_q);
    assign sent_inc = sent_cnt + 8'd1;
    assign hs       = out.out_valid && out.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            lfsr_q        <= 8'h01;
            count_q       <= 8'h00;
            sent_cnt      <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
            out.out_valid <= 1'b0;
            out.a         <= '0;
            out.b         <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        lfsr_q   <= seed_eff;
                        count_q  <= count_n;
                        sent_cnt <= 8'h00;
                        out.a    <= seed_eff[OP_W-1:0];
                        out.b    <= seed_eff[2*OP_W-1:OP_W];
                        if (count_n == 8'h00) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q       <= StRun;
                            busy          <= 1'b1;
                            out.out_valid <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    // Without a handshake everything holds, so a/b stay stable for the consumer.
                    if (hs) begin
                        lfsr_q   <= lfsr_nxt;
                        sent_cnt <= sent_inc;
                        out.a    <= lfsr_nxt[OP_W-1:0];
                        out.b    <= lfsr_nxt[2*OP_W-1:OP_W];
                        if (sent_inc == count_q) begin
                            state_q       <= StDone;
                            busy          <= 1'b0;
                            done          <= 1'b1;
                            out.out_valid <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    done    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q       <= StIdle;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                    out.out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_gen.sv
// Bench for operand_gen: table of runs plus hand-written stall / restart / reset sequences,
// with a scoreboard queue of expected (a, b) pairs checked on every handshake.
module tb_operand_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] count_n;
    logic [7:0] seed;
    logic       busy;
    logic       done;
    logic [7:0] sent_cnt;

    operand_gen_if #(.OP_W(4)) bus ();

    operand_gen #(.OP_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count_n  (count_n),
        .seed     (seed),
        .out      (bus),
        .busy     (busy),
        .done     (done),
        .sent_cnt (sent_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    typedef struct {
        logic [7:0] seed;
        logic [7:0] cnt;
        bit         rnd_ready;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        logic [7:0] exp_sent;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_step(input logic [7:0] x);
        return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
    endfunction

    task automatic push_expected(input logic [7:0] s, input logic [7:0] n);
        logic [7:0] x;
        x = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(x);
            x = model_step(x);
        end
    endtask

    // Scoreboard: inputs are stable from posedge+1, so at negedge valid&&ready is the next handshake.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pair", 1, 0);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("pair_a", int'(bus.a), int'(e[3:0]));
                check("pair_b", int'(bus.b), int'(e[7:4]));
            end
        end
    end

    task automatic do_reset();
        rst   = 1'b1;
        start = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        int budget;
        bit valid_seen;
        push_expected(v.seed, v.cnt);
        seed          = v.seed;
        count_n       = v.cnt;
        start         = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        start   = 1'b0;
        seed    = 8'($urandom);
        count_n = 8'($urandom);
        check("latency_valid", int'(bus.out_valid), int'(v.cnt != 8'h00));
        if (v.cnt != 8'h00) begin
            check("first_a", int'(bus.a), int'(v.exp_a));
            check("first_b", int'(bus.b), int'(v.exp_b));
        end
        cyc        = 0;
        budget     = int'(v.cnt) * 8 + 20;
        valid_seen = bus.out_valid;
        while (!done && cyc < budget) begin
            if (v.rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
            if (bus.out_valid) valid_seen = 1'b1;
        end
        check("done_seen", int'(done), 1);
        if (!v.rnd_ready) check("run_cycles", cyc, int'(v.cnt));
        check("valid_ever", int'(valid_seen), int'(v.cnt != 8'h00));
        check("final_sent", int'(sent_cnt), int'(v.exp_sent));
        check("busy_in_done", int'(busy), 0);
        tick();
        check("done_one_cycle", int'(done), 0);
        check("valid_after_done", int'(bus.out_valid), 0);
        check("sent_retained", int'(sent_cnt), int'(v.exp_sent));
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        bus.out_ready = 1'b1;
    endtask

    initial begin
        vecs[0] = '{seed: 8'h01, cnt: 8'd3,   rnd_ready: 1'b0, exp_a: 4'h1, exp_b: 4'h0, exp_sent: 8'd3};
        vecs[1] = '{seed: 8'h00, cnt: 8'd3,   rnd_ready: 1'b0, exp_a: 4'h1, exp_b: 4'h0, exp_sent: 8'd3};
        vecs[2] = '{seed: 8'hA5, cnt: 8'd6,   rnd_ready: 1'b1, exp_a: 4'h5, exp_b: 4'hA, exp_sent: 8'd6};
        vecs[3] = '{seed: 8'h3C, cnt: 8'd0,   rnd_ready: 1'b0, exp_a: 4'h0, exp_b: 4'h0, exp_sent: 8'd0};
        vecs[4] = '{seed: 8'h80, cnt: 8'd255, rnd_ready: 1'b0, exp_a: 4'h0, exp_b: 4'h8, exp_sent: 8'd255};
        vecs[5] = '{seed: 8'hFF, cnt: 8'd20,  rnd_ready: 1'b1, exp_a: 4'hF, exp_b: 4'hF, exp_sent: 8'd20};

        rst = 1'b1;
        start = 1'b0;
        count_n = 8'd0;
        seed = 8'd0;
        bus.out_ready = 1'b0;

        // Reset state
        do_reset();
        check("rst_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_sent", int'(sent_cnt), 0);
        check("rst_a", int'(bus.a), 0);
        check("rst_b", int'(bus.b), 0);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            tick();
        end

        // Stall after the first handshake: a=2, b=0 must hold with sent_cnt=1.
        push_expected(8'h01, 8'd3);
        seed = 8'h01;
        count_n = 8'd3;
        start = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_a", int'(bus.a), 2);
            check("stall_b", int'(bus.b), 0);
            check("stall_sent", int'(sent_cnt), 1);
            check("stall_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("stall_done", int'(done), 1);
        check("stall_final_sent", int'(sent_cnt), 3);
        check("stall_queue", exp_q.size(), 0);
        tick();
        tick();

        // Start pulse while busy must not retarget the run.
        push_expected(8'h01, 8'd3);
        seed = 8'h01;
        count_n = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        count_n = 8'd9;
        seed = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("busy_start_done", int'(done), 1);
        check("busy_start_sent", int'(sent_cnt), 3);
        tick();
        check("busy_start_idle_valid", int'(bus.out_valid), 0);
        check("busy_start_queue", exp_q.size(), 0);
        exp_q.delete();
        tick();

        // Reset after two handshakes of a five-pair run.
        push_expected(8'h01, 8'd5);
        seed = 8'h01;
        count_n = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("pre_rst_sent", int'(sent_cnt), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_valid", int'(bus.out_valid), 0);
        check("mid_rst_sent", int'(sent_cnt), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_done_after_rst", int'(done), 0);
            check("idle_after_rst", int'(bus.out_valid), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/operand_gen.md
OPERAND_GEN -- requirements
Module: operand_gen

Interface
REQ-001 SHALL have parameter OP_W, default 4, the operand width; only OP_W=4 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  launch request, sampled only in IDLE.
REQ-005 SHALL have port count_n  input  8  number of operand pairs to emit, latched on start.
REQ-006 SHALL have port seed  input  8  LFSR seed, latched on start.
REQ-007 SHALL have port out_ready  input  1  downstream add/sub stage can accept a pair.
REQ-008 SHALL have port out_valid  output  1  a and b are valid.
REQ-009 SHALL have port a  output  OP_W  operand A = lfsr[3:0].
REQ-010 SHALL have port b  output  OP_W  operand B = lfsr[7:4].
REQ-011 SHALL have port busy  output  1  high in RUN.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of run.
REQ-013 SHALL have port sent_cnt  output  8  pairs accepted in the current or last run.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE; all outputs registered.
REQ-015 SHALL use an 8-bit Fibonacci LFSR: fb = q[7]^q[5]^q[4]^q[3]; next = {q[6:0], fb}.
REQ-016 IDLE with start=1 SHALL load lfsr=seed (8'h01 if seed==0), latch count_n, clear sent_cnt; next state RUN, or DONE if count_n==0.
REQ-017 SHALL raise out_valid in the cycle after start is sampled (latency 1).
REQ-018 RUN: out_valid=1, busy=1; a/b driven from the current lfsr.
REQ-019 A handshake SHALL occur when out_valid && out_ready; on handshake sent_cnt increments and lfsr advances one step.
REQ-020 While out_ready=0 in RUN, a, b, lfsr and sent_cnt SHALL hold unchanged.
REQ-021 A handshake with sent_cnt+1 == latched count_n SHALL move to DONE; out_valid drops the next cycle.
REQ-022 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; sent_cnt retains its final value.
REQ-023 start SHALL be ignored in RUN and DONE; changes to count_n/seed after latch SHALL have no effect.
REQ-024 sent_cnt SHALL be 8-bit modulo; count_n=255 SHALL emit 255 pairs without wrap error.

Reset
REQ-025 rst=1 at a clock edge SHALL force state=IDLE, lfsr=8'h01, out_valid=0, busy=0, done=0, sent_cnt=0, a=0, b=0.
REQ-026 rst SHALL override all other inputs, including a handshake in the same cycle; a reset mid-RUN aborts the run with no done pulse.

Verification
REQ-027 Reset: rst=1 for 2 cycles -> out_valid=0, busy=0, done=0, sent_cnt=0.
REQ-028 Basic run: seed=8'h01, count_n=3, out_ready=1 -> (a,b) = (1,0), (2,0), (4,0) on 3 consecutive cycles; done pulses the next cycle; sent_cnt=3.
REQ-029 Stall: same run with out_ready=0 for 3 cycles after the first handshake -> a=2, b=0 held; sent_cnt=1 throughout the stall; run completes with sent_cnt=3.
REQ-030 Zero seed / zero count: seed=0 gives the same sequence as seed=8'h01; count_n=0 gives out_valid never high, done pulse 1 cycle after start.
REQ-031 Start while busy: pulse start with count_n=9 during a 3-pair run -> run still ends at sent_cnt=3.
REQ-032 Reset mid-run: rst=1 after 2 handshakes of a 5-pair run -> next cycle out_valid=0, sent_cnt=0, no done pulse.
